// File: rtl/raster_stream_gen.sv
// -----------------------------------------------------------------------------
// raster_stream_gen
//
// Walks a SCREEN_WIDTH x SCREEN_HEIGHT raster in row-major order. It tells the
// pixel generator which pixel it wants next (cur_x/cur_y/cur_first), takes the
// colours over a valid/ready handshake and packs PPB of them into one output
// beat. Each beat carries SOF/EOL/EOF flags and its coordinates. Beats leave
// through a 2-entry buffer (main + skid), so downstream backpressure never
// loses a pixel. The frame counter and state_dbg are for debug.
//
// Handshake semantics (both the colour input and the beat output):
//   A transfer happens on the rising clk edge where valid && ready are both 1.
//   A producer holding valid must keep its payload stable until the transfer.
//   ready never depends combinationally on valid. in_ready is a function of
//   registered state only. out_valid/out_* come straight from the main register.
//
// Parameters
//   COLOUR_W      bits per pixel colour
//   COORD_W       width of the coordinate outputs; must hold max(W,H)-1
//   SCREEN_WIDTH  pixels per line; must be a multiple of PPB
//   SCREEN_HEIGHT lines per frame
//   PPB           pixels per output beat (1, 2 or 4)
//   FCNT_W        frame counter width
//
// Ports
//   clk, reset    clock; synchronous active-high reset
//   en            frame enable, sampled in IDLE and at the last pixel of a frame
//   cur_x, cur_y  coordinates of the pixel the generator must supply next
//   cur_first     next pixel is (0,0)
//   in_valid      colour_i is valid
//   in_ready      the block accepts colour_i this cycle
//   colour_i      colour for (cur_x, cur_y)
//   out_valid     a beat is presented
//   out_ready     downstream takes the beat
//   out_data      lane k = pixel out_x+k at [k*COLOUR_W +: COLOUR_W]
//   out_x, out_y  coordinates of lane 0 of the beat
//   out_sof       beat holds pixel (0,0)
//   out_eol       beat holds the last pixel of a line
//   out_eof       beat holds the last pixel of the frame
//   frame_done    1-cycle pulse after the EOF beat has been taken downstream
//   frame_count   frames completed (wraps)
//   state_dbg     current FSM state (0 = IDLE, 1 = RUN)
// -----------------------------------------------------------------------------
module raster_stream_gen #(
    parameter int COLOUR_W      = 24,
    parameter int COORD_W       = 16,
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int PPB           = 1,
    parameter int FCNT_W        = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    output logic [COORD_W-1:0]      cur_x,
    output logic [COORD_W-1:0]      cur_y,
    output logic                    cur_first,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [COLOUR_W-1:0]     colour_i,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [PPB*COLOUR_W-1:0] out_data,
    output logic [COORD_W-1:0]      out_x,
    output logic [COORD_W-1:0]      out_y,
    output logic                    out_sof,
    output logic                    out_eol,
    output logic                    out_eof,
    output logic                    frame_done,
    output logic [FCNT_W-1:0]       frame_count,
    output logic [0:0]              state_dbg
);

    // -------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // -------------------------------------------------------------------------
    if (PPB != 1 && PPB != 2 && PPB != 4) begin : g_bad_ppb
        $error("raster_stream_gen: PPB must be 1, 2 or 4");
    end
    if ((SCREEN_WIDTH % PPB) != 0) begin : g_bad_width
        $error("raster_stream_gen: SCREEN_WIDTH must be a multiple of PPB");
    end
    if (SCREEN_WIDTH < 1 || SCREEN_HEIGHT < 1) begin : g_bad_size
        $error("raster_stream_gen: raster must be at least 1x1");
    end
    if ((((SCREEN_WIDTH - 1) >> COORD_W) != 0) ||
        (((SCREEN_HEIGHT - 1) >> COORD_W) != 0)) begin : g_bad_coord
        $error("raster_stream_gen: COORD_W too narrow for the raster");
    end

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    localparam int LANE_W = (PPB > 1) ? $clog2(PPB) : 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [LANE_W-1:0]  LAST_LANE = LANE_W'(PPB - 1);
    localparam logic [COORD_W-1:0] X_LAST    = COORD_W'(SCREEN_WIDTH - 1);
    localparam logic [COORD_W-1:0] Y_LAST    = COORD_W'(SCREEN_HEIGHT - 1);
    // Lane 0 of a beat sits PPB-1 pixels left of the pixel that completes it.
    localparam logic [COORD_W-1:0] X0_OFF    = COORD_W'(PPB - 1);

    typedef struct packed {
        logic [PPB*COLOUR_W-1:0] data;
        logic [COORD_W-1:0]      x;
        logic [COORD_W-1:0]      y;
        logic                    sof;
        logic                    eol;
        logic                    eof;
    } beat_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [0:0]              state;
    logic [LANE_W-1:0]       lane;
    logic [1:0]              count;      // beats held: 0, 1 (main) or 2 (main + skid)
    beat_t                   main_q;
    beat_t                   skid_q;
    beat_t                   new_beat;
    logic [PPB*COLOUR_W-1:0] beat_data;

    logic accept;
    logic push;
    logic pop;
    logic last_pixel;
    logic last_lane;

    // -------------------------------------------------------------------------
    // Handshake decode
    // -------------------------------------------------------------------------
    assign last_lane  = (lane == LAST_LANE);
    assign last_pixel = (cur_x == X_LAST) && (cur_y == Y_LAST);

    // Only the pixel that completes a beat needs buffer space. Earlier lanes go
    // into the pack register, so they are taken even with a full buffer.
    assign in_ready  = (state == S_RUN) && (!last_lane || count != 2'd2);
    assign accept    = in_valid && in_ready;
    assign push      = accept && last_lane;

    assign out_valid = (count != 2'd0);
    assign pop       = out_valid && out_ready;

    // -------------------------------------------------------------------------
    // Lane packing. The final lane is taken straight from colour_i so a beat
    // is pushed in the same cycle as its last pixel is accepted.
    // -------------------------------------------------------------------------
    if (PPB == 1) begin : g_single
        assign beat_data = colour_i;
    end else begin : g_pack
        logic [(PPB-1)*COLOUR_W-1:0] pack_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                pack_q <= '0;
            end else if (accept && !last_lane) begin
                pack_q[int'(lane)*COLOUR_W +: COLOUR_W] <= colour_i;
            end
        end

        assign beat_data = {colour_i, pack_q};
    end

    // Beat assembled at the moment its last pixel is accepted.
    always_comb begin
        new_beat      = '0;
        new_beat.data = beat_data;
        new_beat.x    = cur_x - X0_OFF;
        new_beat.y    = cur_y;
        new_beat.sof  = (new_beat.x == '0) && (cur_y == '0);
        // SCREEN_WIDTH is a multiple of PPB, so the beat ends the line exactly
        // when its last pixel is the last pixel of the line.
        new_beat.eol  = (cur_x == X_LAST);
        new_beat.eof  = (cur_x == X_LAST) && (cur_y == Y_LAST);
    end

    // -------------------------------------------------------------------------
    // FSM and raster position
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cur_x     <= '0;
            cur_y     <= '0;
            cur_first <= 1'b1;
            lane      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (en) begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    // Frames are never truncated: en only matters once the
                    // last pixel of the frame has been taken.
                    if (accept && last_pixel && !en) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (accept) begin
                lane <= last_lane ? '0 : lane + LANE_W'(1);

                if (cur_x == X_LAST) begin
                    cur_x <= '0;
                    if (cur_y == Y_LAST) begin
                        cur_y     <= '0;
                        cur_first <= 1'b1;
                    end else begin
                        cur_y     <= cur_y + COORD_W'(1);
                        cur_first <= 1'b0;
                    end
                end else begin
                    cur_x     <= cur_x + COORD_W'(1);
                    cur_first <= 1'b0;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Two-entry output buffer. main_q drives the outputs, skid_q holds the
    // beat that arrived while main_q was stalled. FIFO order is main, skid.
    // A push into a full buffer cannot occur because in_ready blocks it.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= 2'd0;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        main_q <= new_beat;
                        count  <= 2'd1;
                    end else begin
                        skid_q <= new_beat;
                        count  <= 2'd2;
                    end
                end
                2'b01: begin
                    if (count == 2'd2) begin
                        main_q <= skid_q;
                    end
                    count <= count - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; the queue advances by one.
                    if (count == 2'd1) begin
                        main_q <= new_beat;
                    end else begin
                        main_q <= skid_q;
                        skid_q <= new_beat;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Frame completion: counted when the EOF beat leaves the block.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_done  <= 1'b0;
            frame_count <= '0;
        end else begin
            frame_done <= pop && main_q.eof;
            if (pop && main_q.eof) begin
                frame_count <= frame_count + FCNT_W'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign out_data  = main_q.data;
    assign out_x     = main_q.x;
    assign out_y     = main_q.y;
    assign out_sof   = main_q.sof;
    assign out_eol   = main_q.eol;
    assign out_eof   = main_q.eof;
    assign state_dbg = state;

endmodule

// File: tb/tb_raster_stream_gen.sv
// -----------------------------------------------------------------------------
// Bench for raster_stream_gen. Two instances run side by side on a 4x2 raster
// with 8-bit colours: u0 packs one pixel per beat (PPB=1), u1 packs two (PPB=2).
// Each instance has its own randomised driver. Its monitor predicts the beats
// from the pixels it accepted: raster position from the pixel index, beat
// contents from the pixel group. Expected beats queue up in exp_q.
// -----------------------------------------------------------------------------
module tb_raster_stream_gen;

    localparam int W   = 4;
    localparam int H   = 2;
    localparam int CW  = 8;
    localparam int XW  = 8;
    localparam int FW  = 16;
    localparam int BW  = 16 + XW + XW + 3;   // {data16, x, y, sof, eol, eof}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset = 1'b1;

    // ---------------- per-instance pins ----------------
    logic          en_s       [2];
    logic          in_valid_s [2];
    logic          in_ready_s [2];
    logic [CW-1:0] colour_s   [2];
    logic          out_valid_s[2];
    logic          out_ready_s[2];
    logic [15:0]   out_data_s [2];
    logic [XW-1:0] cur_x_s    [2];
    logic [XW-1:0] cur_y_s    [2];
    logic          cur_first_s[2];
    logic [XW-1:0] out_x_s    [2];
    logic [XW-1:0] out_y_s    [2];
    logic          sof_s      [2];
    logic          eol_s      [2];
    logic          eof_s      [2];
    logic          fd_s       [2];
    logic [FW-1:0] fcnt_s     [2];
    logic [0:0]    state_s    [2];

    // ---------------- stimulus knobs and model status ----------------
    int vld_pct  = 0;
    int rdy_pct  = 100;
    int en_limit = 0;      // en stays high while fewer pixels than this were accepted
    int acc_cnt [2];
    int pop_cnt [2];
    int fcnt_exp[2];
    int qsz     [2];
    logic [CW-1:0] next_col[2];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        cycles(n);
        reset = 1'b0;
    endtask

    // Wait until both instances have finished `target` frames and gone idle.
    task automatic wait_frames(input int target, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (fcnt_exp[0] >= target && fcnt_exp[1] >= target &&
                state_s[0] == 1'b0 && state_s[1] == 1'b0 && qsz[0] == 0 && qsz[1] == 0)
                break;
            cycles(1);
        end
        check($sformatf("wait_frames_%0d_timeout", target), 64'(i < budget), 64'(1));
        cycles(2);
    endtask

    // ---------------- instances, drivers, monitors ----------------
    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int P = g + 1;
        logic [P*CW-1:0] od;
        logic [BW-1:0]   exp_q[$];
        logic [BW-1:0]   obs;
        logic [BW-1:0]   held;
        logic [BW-1:0]   exp_b;
        logic [15:0]     pend;
        logic            hold;
        logic            fd_exp;
        int              pn;
        int              pix;

        raster_stream_gen #(
            .COLOUR_W(CW), .COORD_W(XW), .SCREEN_WIDTH(W), .SCREEN_HEIGHT(H),
            .PPB(P), .FCNT_W(FW)
        ) u_dut (
            .clk(clk), .reset(reset), .en(en_s[g]),
            .cur_x(cur_x_s[g]), .cur_y(cur_y_s[g]), .cur_first(cur_first_s[g]),
            .in_valid(in_valid_s[g]), .in_ready(in_ready_s[g]), .colour_i(colour_s[g]),
            .out_valid(out_valid_s[g]), .out_ready(out_ready_s[g]), .out_data(od),
            .out_x(out_x_s[g]), .out_y(out_y_s[g]),
            .out_sof(sof_s[g]), .out_eol(eol_s[g]), .out_eof(eof_s[g]),
            .frame_done(fd_s[g]), .frame_count(fcnt_s[g]), .state_dbg(state_s[g])
        );

        assign out_data_s[g] = 16'(od);

        // Driver: new random inputs #1 after every rising edge.
        initial begin
            en_s[g] = 1'b0; in_valid_s[g] = 1'b0; out_ready_s[g] = 1'b0;
            colour_s[g] = '0; next_col[g] = 8'd1; acc_cnt[g] = 0;
            forever begin
                @(posedge clk);
                #1;
                in_valid_s[g]  = (int'($urandom_range(99)) < vld_pct);
                out_ready_s[g] = (int'($urandom_range(99)) < rdy_pct);
                colour_s[g]    = next_col[g];
                en_s[g]        = (acc_cnt[g] < en_limit);
            end
        end

        // Monitor / reference model, sampled on the falling edge. Handshakes
        // seen here complete at the next rising edge.
        initial begin
            exp_q.delete(); pn = 0; pix = 0; pend = '0; hold = 1'b0; fd_exp = 1'b0;
            pop_cnt[g] = 0; fcnt_exp[g] = 0; qsz[g] = 0;
            forever begin
                @(negedge clk);
                if (reset) begin
                    exp_q.delete(); pn = 0; pix = 0; pend = '0; hold = 1'b0; fd_exp = 1'b0;
                    acc_cnt[g] = 0; pop_cnt[g] = 0; fcnt_exp[g] = 0; next_col[g] = 8'd1;
                end else begin
                    obs = {out_data_s[g], out_x_s[g], out_y_s[g], sof_s[g], eol_s[g], eof_s[g]};
                    check($sformatf("u%0d_frame_done", g), 64'(fd_s[g]), 64'(fd_exp));
                    check($sformatf("u%0d_frame_count", g), 64'(fcnt_s[g]), 64'(fcnt_exp[g] % 65536));
                    check($sformatf("u%0d_cur_x", g), 64'(cur_x_s[g]), 64'(pix % W));
                    check($sformatf("u%0d_cur_y", g), 64'(cur_y_s[g]), 64'(pix / W));
                    check($sformatf("u%0d_cur_first", g), 64'(cur_first_s[g]), 64'(pix == 0));
                    if (hold) begin
                        check($sformatf("u%0d_hold_valid", g), 64'(out_valid_s[g]), 64'(1));
                        check($sformatf("u%0d_hold_beat", g), 64'(obs), 64'(held));
                    end
                    fd_exp = 1'b0;

                    if (out_valid_s[g] && out_ready_s[g]) begin
                        pop_cnt[g]++;
                        if (exp_q.size() == 0) begin
                            check($sformatf("u%0d_spurious_beat", g), 64'(obs), 64'(0));
                        end else begin
                            exp_b = exp_q.pop_front();
                            check($sformatf("u%0d_beat", g), 64'(obs), 64'(exp_b));
                            if (exp_b[0]) begin
                                fcnt_exp[g]++;
                                fd_exp = 1'b1;
                            end
                        end
                    end
                    hold = out_valid_s[g] && !out_ready_s[g];
                    held = obs;

                    if (in_valid_s[g] && in_ready_s[g]) begin
                        int p0, x0, y0;
                        logic eol;
                        pend[pn*CW +: CW] = colour_s[g];
                        pn++;
                        acc_cnt[g]++;
                        next_col[g] = next_col[g] + 8'd1;
                        if (pn == P) begin
                            p0  = pix - (P - 1);
                            x0  = p0 % W;
                            y0  = p0 / W;
                            eol = (x0 + P == W);
                            exp_q.push_back({pend, 8'(x0), 8'(y0), 1'(p0 == 0), eol, eol && (y0 == H - 1)});
                            pn   = 0;
                            pend = '0;
                        end
                        pix = (pix + 1) % (W * H);
                    end
                    qsz[g] = exp_q.size();
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- test sequence ----------------
    initial begin
        // Mid-stream reset held 3 cycles: all outputs return to reset values.
        vld_pct = 70; rdy_pct = 60; en_limit = 1000;
        do_reset(2);
        cycles(11);
        reset = 1'b1;
        cycles(3);
        for (int g = 0; g < 2; g++) begin
            check($sformatf("rst_u%0d_in_ready", g),    64'(in_ready_s[g]),  64'(0));
            check($sformatf("rst_u%0d_out_valid", g),   64'(out_valid_s[g]), 64'(0));
            check($sformatf("rst_u%0d_out_data", g),    64'(out_data_s[g]),  64'(0));
            check($sformatf("rst_u%0d_out_xy", g),      64'({out_x_s[g], out_y_s[g]}), 64'(0));
            check($sformatf("rst_u%0d_flags", g),       64'({sof_s[g], eol_s[g], eof_s[g]}), 64'(0));
            check($sformatf("rst_u%0d_frame_done", g),  64'(fd_s[g]),        64'(0));
            check($sformatf("rst_u%0d_frame_count", g), 64'(fcnt_s[g]),      64'(0));
            check($sformatf("rst_u%0d_cur_xy", g),      64'({cur_x_s[g], cur_y_s[g]}), 64'(0));
            check($sformatf("rst_u%0d_cur_first", g),   64'(cur_first_s[g]), 64'(1));
            check($sformatf("rst_u%0d_state", g),       64'(state_s[g]),     64'(0));
        end
        en_limit = 4;
        reset = 1'b0;
        wait_frames(1, 500);

        // Full-rate single frame, colours 1..8.
        vld_pct = 100; rdy_pct = 100; en_limit = 4;
        do_reset(2);
        wait_frames(1, 200);
        check("t2_u0_beats", 64'(pop_cnt[0]), 64'(8));
        check("t3_u1_beats", 64'(pop_cnt[1]), 64'(4));
        check("t2_u0_fcount", 64'(fcnt_s[0]), 64'(1));
        check("t3_u1_fcount", 64'(fcnt_s[1]), 64'(1));

        // Downstream stalled from the start: buffer fills, input stops.
        vld_pct = 100; rdy_pct = 0; en_limit = 4;
        do_reset(2);
        cycles(20);
        check("t4_u0_in_ready", 64'(in_ready_s[0]), 64'(0));
        check("t4_u1_in_ready", 64'(in_ready_s[1]), 64'(0));
        check("t4_u0_accepts",  64'(acc_cnt[0]),    64'(2));
        check("t4_u1_accepts",  64'(acc_cnt[1]),    64'(5));
        rdy_pct = 100;
        wait_frames(1, 200);
        check("t4_u0_beats", 64'(pop_cnt[0]), 64'(8));
        check("t4_u1_beats", 64'(pop_cnt[1]), 64'(4));

        // en dropped after the 3rd pixel: frame completes, then IDLE.
        vld_pct = 100; rdy_pct = 70; en_limit = 3;
        do_reset(2);
        wait_frames(1, 300);
        check("t5_u0_idle_ready", 64'(in_ready_s[0]), 64'(0));
        check("t5_u1_idle_ready", 64'(in_ready_s[1]), 64'(0));
        check("t5_u0_beats", 64'(pop_cnt[0]), 64'(8));
        check("t5_u1_beats", 64'(pop_cnt[1]), 64'(4));
        cycles(5);
        check("t5_u0_still_idle", 64'(state_s[0]), 64'(0));
        en_limit = 12;   // high at the end of frame 1 only: one more frame
        wait_frames(2, 300);
        check("t5_u0_fcount", 64'(fcnt_s[0]), 64'(2));
        check("t5_u1_fcount", 64'(fcnt_s[1]), 64'(2));

        // Random valid/ready over 3 frames.
        vld_pct = 60; rdy_pct = 50; en_limit = 20;
        do_reset(2);
        wait_frames(3, 3000);
        check("t6_u0_fcount", 64'(fcnt_s[0]), 64'(3));
        check("t6_u1_fcount", 64'(fcnt_s[1]), 64'(3));
        check("t6_u0_beats",  64'(pop_cnt[0]), 64'(24));
        check("t6_u1_beats",  64'(pop_cnt[1]), 64'(12));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
